// File: rtl/distortion_gain_ctrl.sv
// -----------------------------------------------------------------------------
// distortion_gain_ctrl
//
// Gain sequencer for the distortion stage. It turns a requested gain setting
// into a click-free ramp that changes by at most STEP per audio sample. Bypass
// entry and exit always pass through unity gain, so the wet/dry mux switches
// while the wet path is at unity.
//
// Gain format is Q(BITS_PER_LEVEL) fixed point, so UNITY = 1 << BITS_PER_LEVEL.
//
// Ports
//   clk_i           system clock
//   rst_ni          synchronous reset, active low
//   sample_valid_i  one-cycle strobe per audio sample; gain only moves on it
//   target_gain_i   signed requested gain, latched on target_load_i
//   target_load_i   one-cycle strobe: latch clamped target_gain_i
//   bypass_req_i    level: 1 = bypass the distortion
//   gain_o          signed registered gain to the distortion datapath
//   bypass_sel_o    registered: 1 = output mux selects the dry signal
//   busy_o          registered: 1 while in RAMP or TO_BYP
//   ramp_done_o     one-cycle pulse when a RAMP reaches its target
// -----------------------------------------------------------------------------
module distortion_gain_ctrl #(
    parameter int BITS_PER_LEVEL = 12,
    parameter int STEP           = 16,
    parameter int GAIN_MIN       = 0,
    parameter int GAIN_MAX       = 32767
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        sample_valid_i,
    input  logic [15:0] target_gain_i,
    input  logic        target_load_i,
    input  logic        bypass_req_i,
    output logic [15:0] gain_o,
    output logic        bypass_sel_o,
    output logic        busy_o,
    output logic        ramp_done_o
);

    localparam logic signed [15:0] UNITY    = 16'(1 << BITS_PER_LEVEL);
    localparam logic signed [15:0] GMIN     = 16'(GAIN_MIN);
    localparam logic signed [15:0] GMAX     = 16'(GAIN_MAX);
    localparam logic signed [16:0] STEP_S17 = 17'(STEP);

    typedef enum logic [1:0] {
        S_HOLD,
        S_RAMP,
        S_TO_BYP,
        S_BYP
    } state_t;

    state_t             state_q, state_d;
    logic signed [15:0] gain_q, gain_d;
    logic signed [15:0] target_q, target_d;
    logic               bypass_sel_q, bypass_sel_d;
    logic               busy_q, busy_d;
    logic               ramp_done_q, ramp_done_d;

    logic signed [15:0] target_in;
    logic signed [15:0] target_clamped;
    logic signed [15:0] step_to_target;
    logic signed [15:0] step_to_unity;

    // One step of the ramp: the difference is taken at 17 bits so that the
    // full signed 16-bit span cannot overflow. Within STEP we land exactly on
    // the destination, otherwise we move by STEP in its direction.
    function automatic logic signed [15:0] step_toward(
        input logic signed [15:0] cur,
        input logic signed [15:0] dst
    );
        logic signed [16:0] diff;
        logic signed [16:0] mag;
        logic signed [16:0] nxt;
        diff = {dst[15], dst} - {cur[15], cur};
        mag  = diff[16] ? -diff : diff;
        if (mag <= STEP_S17) begin
            nxt = {dst[15], dst};
        end else if (diff[16]) begin
            nxt = {cur[15], cur} - STEP_S17;
        end else begin
            nxt = {cur[15], cur} + STEP_S17;
        end
        return nxt[15:0];
    endfunction

    assign target_in = $signed(target_gain_i);

    always_comb begin
        target_clamped = target_in;
        if (target_in < GMIN) begin
            target_clamped = GMIN;
        end else if (target_in > GMAX) begin
            target_clamped = GMAX;
        end
    end

    // Steps always use the target held before this edge, so a load arriving
    // together with a sample strobe only affects the following strobe.
    assign step_to_target = step_toward(gain_q, target_q);
    assign step_to_unity  = step_toward(gain_q, UNITY);

    always_comb begin
        state_d      = state_q;
        gain_d       = gain_q;
        target_d     = target_load_i ? target_clamped : target_q;
        bypass_sel_d = bypass_sel_q;
        ramp_done_d  = 1'b0;

        case (state_q)
            S_HOLD: begin
                if (bypass_req_i) begin
                    state_d = S_TO_BYP;
                end else if (target_load_i && (target_clamped != gain_q)) begin
                    state_d = S_RAMP;
                end
            end

            S_RAMP: begin
                if (bypass_req_i) begin
                    state_d = S_TO_BYP;
                end else if (sample_valid_i) begin
                    gain_d = step_to_target;
                    if (step_to_target == target_q) begin
                        state_d     = S_HOLD;
                        ramp_done_d = 1'b1;
                    end
                end
            end

            S_TO_BYP: begin
                if (!bypass_req_i) begin
                    state_d = S_RAMP;
                end else if (sample_valid_i) begin
                    gain_d = step_to_unity;
                    // Switch the mux on the very edge gain lands on unity.
                    if (step_to_unity == UNITY) begin
                        state_d      = S_BYP;
                        bypass_sel_d = 1'b1;
                    end
                end
            end

            S_BYP: begin
                if (!bypass_req_i) begin
                    bypass_sel_d = 1'b0;
                    state_d      = (target_q != UNITY) ? S_RAMP : S_HOLD;
                end
            end

            default: begin
                state_d = S_HOLD;
            end
        endcase

        busy_d = (state_d == S_RAMP) || (state_d == S_TO_BYP);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= S_HOLD;
            gain_q       <= UNITY;
            target_q     <= UNITY;
            bypass_sel_q <= 1'b0;
            busy_q       <= 1'b0;
            ramp_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            gain_q       <= gain_d;
            target_q     <= target_d;
            bypass_sel_q <= bypass_sel_d;
            busy_q       <= busy_d;
            ramp_done_q  <= ramp_done_d;
        end
    end

    assign gain_o       = gain_q;
    assign bypass_sel_o = bypass_sel_q;
    assign busy_o       = busy_q;
    assign ramp_done_o  = ramp_done_q;

endmodule

// File: tb/tb_distortion_gain_ctrl.sv
// -----------------------------------------------------------------------------
// tb_distortion_gain_ctrl
//
// Directed bench for distortion_gain_ctrl with hand-computed expected values
// (default parameters: UNITY = 4096, STEP = 16, clamp range [0, 32767]).
// -----------------------------------------------------------------------------
module tb_distortion_gain_ctrl;

    logic        clk;
    logic        rst_n;
    logic        sample_valid;
    logic [15:0] target_gain;
    logic        target_load;
    logic        bypass_req;
    logic [15:0] gain;
    logic        bypass_sel;
    logic        busy;
    logic        ramp_done;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt;

    distortion_gain_ctrl dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .sample_valid_i (sample_valid),
        .target_gain_i  (target_gain),
        .target_load_i  (target_load),
        .bypass_req_i   (bypass_req),
        .gain_o         (gain),
        .bypass_sel_o   (bypass_sel),
        .busy_o         (busy),
        .ramp_done_o    (ramp_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive strobes, let one posedge pass, sample 1 time unit later.
    task automatic tick(input logic sv, input logic ld, input int tg);
        sample_valid = sv;
        target_load  = ld;
        target_gain  = 16'(tg);
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        target_load  = 1'b0;
        $display("[TB] t=%0t sv=%0d ld=%0d tg=%0d byp_req=%0d -> gain=%0d bsel=%0d busy=%0d done=%0d",
                 $time, sv, ld, tg, bypass_req, $signed(gain), bypass_sel, busy, ramp_done);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(1'b0, 1'b0, 0);
        tick(1'b0, 1'b0, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        target_load  = 1'b0;
        target_gain  = 16'd0;
        bypass_req   = 1'b0;

        // 1. Reset
        do_reset();
        chk("rst_gain", $signed(gain), 4096);
        chk("rst_bsel", bypass_sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", ramp_done, 0);

        // 2. Ramp up by 4 full steps
        tick(1'b0, 1'b1, 4160);
        chk("t2_busy_start", busy, 1);
        chk("t2_gain_start", $signed(gain), 4096);
        for (int i = 1; i <= 4; i++) begin
            tick(1'b1, 1'b0, 0);
            chk($sformatf("t2_gain_%0d", i), $signed(gain), 4096 + 16 * i);
            chk($sformatf("t2_done_%0d", i), ramp_done, (i == 4) ? 1 : 0);
            chk($sformatf("t2_busy_%0d", i), busy, (i < 4) ? 1 : 0);
        end
        tick(1'b0, 1'b0, 0);
        chk("t2_done_pulse", ramp_done, 0);

        // 3a. Clamp negative target to 0; 256 strobes from unity
        tick(1'b0, 1'b1, 4096);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 0);
        chk("t3_back_unity", $signed(gain), 4096);
        tick(1'b0, 1'b1, -5);
        cnt = 0;
        for (int i = 0; i < 400; i++) begin
            tick(1'b1, 1'b0, 0);
            cnt++;
            if ($signed(gain) <= 0) break;
        end
        chk("t3_strobes", cnt, 256);
        chk("t3_gain_zero", $signed(gain), 0);
        chk("t3_done", ramp_done, 1);
        tick(1'b1, 1'b0, 0);
        chk("t3_stays_zero", $signed(gain), 0);

        // 3b. Partial step
        do_reset();
        tick(1'b0, 1'b1, 4101);
        tick(1'b1, 1'b0, 0);
        chk("t3_partial_gain", $signed(gain), 4101);
        chk("t3_partial_done", ramp_done, 1);
        chk("t3_partial_busy", busy, 0);

        // 4. Mid-ramp retarget
        do_reset();
        tick(1'b0, 1'b1, 4400);
        tick(1'b1, 1'b0, 0);
        chk("t4_g1", $signed(gain), 4112);
        tick(1'b1, 1'b0, 0);
        chk("t4_g2", $signed(gain), 4128);
        tick(1'b0, 1'b1, 4000);
        chk("t4_hold_no_sv", $signed(gain), 4128);
        for (int k = 1; k <= 8; k++) begin
            tick(1'b1, 1'b0, 0);
            chk($sformatf("t4_gain_%0d", k), $signed(gain), 4128 - 16 * k);
            chk($sformatf("t4_done_%0d", k), ramp_done, (k == 8) ? 1 : 0);
        end

        // 5a. Bypass entry through unity and exit back to 4160
        tick(1'b0, 1'b1, 4160);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 0);
        chk("t5_at_4160", $signed(gain), 4160);
        bypass_req = 1'b1;
        tick(1'b0, 1'b0, 0);
        chk("t5_tobyp_busy", busy, 1);
        chk("t5_tobyp_bsel", bypass_sel, 0);
        for (int i = 1; i <= 4; i++) begin
            tick(1'b1, 1'b0, 0);
            chk($sformatf("t5_down_%0d", i), $signed(gain), 4160 - 16 * i);
            chk($sformatf("t5_bsel_%0d", i), bypass_sel, (i == 4) ? 1 : 0);
            chk($sformatf("t5_nodone_%0d", i), ramp_done, 0);
        end
        chk("t5_byp_busy", busy, 0);
        tick(1'b1, 1'b0, 0);
        chk("t5_byp_hold", $signed(gain), 4096);
        bypass_req = 1'b0;
        tick(1'b0, 1'b0, 0);
        chk("t5_rel_bsel", bypass_sel, 0);
        chk("t5_rel_busy", busy, 1);
        for (int i = 1; i <= 4; i++) begin
            tick(1'b1, 1'b0, 0);
            chk($sformatf("t5_up_%0d", i), $signed(gain), 4096 + 16 * i);
            chk($sformatf("t5_updone_%0d", i), ramp_done, (i == 4) ? 1 : 0);
        end

        // 5b. Bypass released mid-TO_BYP
        bypass_req = 1'b1;
        tick(1'b0, 1'b0, 0);
        tick(1'b1, 1'b0, 0);
        chk("t5b_g1", $signed(gain), 4144);
        tick(1'b1, 1'b0, 0);
        chk("t5b_g2", $signed(gain), 4128);
        chk("t5b_bsel_a", bypass_sel, 0);
        bypass_req = 1'b0;
        tick(1'b0, 1'b0, 0);
        chk("t5b_ramp_busy", busy, 1);
        chk("t5b_hold_gain", $signed(gain), 4128);
        tick(1'b1, 1'b0, 0);
        chk("t5b_g3", $signed(gain), 4144);
        chk("t5b_bsel_b", bypass_sel, 0);
        tick(1'b1, 1'b0, 0);
        chk("t5b_g4", $signed(gain), 4160);
        chk("t5b_done", ramp_done, 1);

        // 6a. Reset mid-ramp (sample strobe during reset must not step)
        do_reset();
        tick(1'b0, 1'b1, 4400);
        tick(1'b1, 1'b0, 0);
        tick(1'b1, 1'b0, 0);
        chk("t6_pre_gain", $signed(gain), 4128);
        rst_n = 1'b0;
        tick(1'b1, 1'b0, 0);
        rst_n = 1'b1;
        chk("t6_rst_gain", $signed(gain), 4096);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", ramp_done, 0);
        tick(1'b1, 1'b0, 0);
        chk("t6_after_rst_gain", $signed(gain), 4096);
        chk("t6_after_rst_busy", busy, 0);

        // 6b. Simultaneous load + sample strobe uses old target
        tick(1'b0, 1'b1, 4160);
        tick(1'b1, 1'b0, 0);
        tick(1'b1, 1'b0, 0);
        chk("t6_sim_pre", $signed(gain), 4128);
        tick(1'b1, 1'b1, 4000);
        chk("t6_sim_oldtgt", $signed(gain), 4144);
        tick(1'b1, 1'b0, 0);
        chk("t6_sim_newtgt", $signed(gain), 4128);
        chk("t6_sim_busy", busy, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
